// File: rtl/offnariscv_axi_ram_if.sv
// rtl/offnariscv_axi_ram_if.sv - AXI4 read/write channel bundle between the core master and the RAM slave
interface offnariscv_axi_ram_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arburst, arvalid, input arready,
        input rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input awid, awaddr, awlen, awburst, awvalid, output awready,
        input wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input arid, araddr, arlen, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/offnariscv_axi_ram.sv
// rtl/offnariscv_axi_ram.sv - single-outstanding AXI4 slave RAM with burst sequencing and byte strobes
module offnariscv_axi_ram #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_BYTES  = 65536
) (
    input  logic                 clk,
    input  logic                 rst,
    offnariscv_axi_ram_if.slave  bus
);
    localparam int STRB_W    = DATA_WIDTH / 8;
    localparam int BYTE_BITS = $clog2(STRB_W);
    localparam int MEM_BITS  = $clog2(MEM_BYTES);
    localparam int IDX_W     = MEM_BITS - BYTE_BITS;
    localparam int WORDS     = 1 << IDX_W;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_WRESP} state_t;
    typedef enum logic {PRIO_READ, PRIO_WRITE} prio_t;

    logic [DATA_WIDTH-1:0] mem [WORDS];

    state_t                state_q, state_d;
    prio_t                 prio_q, prio_d;
    logic [IDX_W-1:0]      addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            beat_q, beat_d;
    logic [1:0]            mode_q, mode_d;
    logic                  err_q, err_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  bvalid_q, bvalid_d;
    logic [ID_WIDTH-1:0]   bid_q, bid_d;
    logic [1:0]            bresp_q, bresp_d;

    logic                  ar_ready, aw_ready, w_ready, wr_en;
    logic [2:0]            ar_dec, aw_dec;
    logic [IDX_W-1:0]      ar_word, aw_word, nxt_word;
    logic                  last_beat, err_nxt;
    logic                  unused_addr;

    assign ar_word     = bus.araddr[MEM_BITS-1:BYTE_BITS];
    assign aw_word     = bus.awaddr[MEM_BITS-1:BYTE_BITS];
    assign unused_addr = ^{bus.araddr, bus.awaddr};

    // Returns {err, effective_mode}; illegal WRAP lengths and the reserved type fall back to INCR.
    function automatic logic [2:0] decode_burst(input logic [1:0] burst, input logic [7:0] len);
        logic wrap_ok;
        wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        case (burst)
            BURST_FIXED: return {1'b0, BURST_FIXED};
            BURST_INCR:  return {1'b0, BURST_INCR};
            BURST_WRAP:  return wrap_ok ? {1'b0, BURST_WRAP} : {1'b1, BURST_INCR};
            default:     return {1'b1, BURST_INCR};
        endcase
    endfunction

    function automatic logic [IDX_W-1:0] next_word(input logic [IDX_W-1:0] w, input logic [1:0] mode,
                                                    input logic [7:0] len);
        logic [IDX_W-1:0] inc, mask;
        inc  = w + 1'b1;
        mask = IDX_W'(len);
        case (mode)
            BURST_FIXED: return w;
            BURST_WRAP:  return (w & ~mask) | (inc & mask);
            default:     return inc;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        addr_d    = addr_q;
        len_d     = len_q;
        beat_d    = beat_q;
        mode_d    = mode_q;
        err_d     = err_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        rid_d     = rid_q;
        rresp_d   = rresp_q;
        bvalid_d  = bvalid_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        ar_ready  = 1'b0;
        aw_ready  = 1'b0;
        w_ready   = 1'b0;
        wr_en     = 1'b0;
        last_beat = 1'b0;
        err_nxt   = err_q;
        ar_dec    = decode_burst(bus.arburst, bus.arlen);
        aw_dec    = decode_burst(bus.awburst, bus.awlen);
        nxt_word  = next_word(addr_q, mode_q, len_q);

        case (state_q)
            S_IDLE: begin
                if (!rst) begin
                    ar_ready = bus.arvalid & (!bus.awvalid | (prio_q == PRIO_READ));
                    aw_ready = bus.awvalid & (!bus.arvalid | (prio_q == PRIO_WRITE));
                end
                if (ar_ready) begin
                    // The first beat is fetched on the handshake edge so it is valid one cycle later.
                    state_d  = S_RD;
                    prio_d   = PRIO_WRITE;
                    addr_d   = ar_word;
                    len_d    = bus.arlen;
                    beat_d   = 8'd0;
                    mode_d   = ar_dec[1:0];
                    rvalid_d = 1'b1;
                    rlast_d  = (bus.arlen == 8'd0);
                    rdata_d  = mem[ar_word];
                    rid_d    = bus.arid;
                    rresp_d  = ar_dec[2] ? RESP_SLVERR : RESP_OKAY;
                end else if (aw_ready) begin
                    state_d = S_WR;
                    prio_d  = PRIO_READ;
                    addr_d  = aw_word;
                    len_d   = bus.awlen;
                    beat_d  = 8'd0;
                    mode_d  = aw_dec[1:0];
                    err_d   = aw_dec[2];
                    bid_d   = bus.awid;
                end
            end
            S_RD: begin
                if (rvalid_q && bus.rready) begin
                    if (rlast_q) begin
                        state_d  = S_IDLE;
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                    end else begin
                        addr_d  = nxt_word;
                        beat_d  = beat_q + 8'd1;
                        rdata_d = mem[nxt_word];
                        rlast_d = ((beat_q + 8'd1) == len_q);
                    end
                end
            end
            S_WR: begin
                w_ready = 1'b1;
                if (bus.wvalid) begin
                    // The beat counter ends the burst; a disagreeing wlast only flags the response.
                    wr_en     = 1'b1;
                    last_beat = (beat_q == len_q);
                    err_nxt   = err_q | (bus.wlast != last_beat);
                    err_d     = err_nxt;
                    if (last_beat) begin
                        state_d  = S_WRESP;
                        bvalid_d = 1'b1;
                        bresp_d  = err_nxt ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        addr_d = nxt_word;
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            S_WRESP: begin
                if (bus.bready) begin
                    state_d  = S_IDLE;
                    bvalid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            prio_q   <= PRIO_READ;
            addr_q   <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            mode_q   <= BURST_INCR;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rdata_q  <= '0;
            rid_q    <= '0;
            rresp_q  <= RESP_OKAY;
            bvalid_q <= 1'b0;
            bid_q    <= '0;
            bresp_q  <= RESP_OKAY;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            mode_q   <= mode_d;
            err_q    <= err_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
            rdata_q  <= rdata_d;
            rid_q    <= rid_d;
            rresp_q  <= rresp_d;
            bvalid_q <= bvalid_d;
            bid_q    <= bid_d;
            bresp_q  <= bresp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (bus.wstrb[b]) mem[addr_q][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
        end
    end

    assign bus.arready = ar_ready;
    assign bus.awready = aw_ready;
    assign bus.wready  = w_ready;
    assign bus.rvalid  = rvalid_q;
    assign bus.rlast   = rlast_q;
    assign bus.rdata   = rdata_q;
    assign bus.rid     = rid_q;
    assign bus.rresp   = rresp_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bid     = bid_q;
    assign bus.bresp   = bresp_q;
endmodule

// File: tb/tb_offnariscv_axi_ram.sv
// tb/tb_offnariscv_axi_ram.sv - scoreboard bench for the AXI4 RAM slave
module tb_offnariscv_axi_ram;
    localparam int DW = 64;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam logic [1:0] OK = 2'b00, SE = 2'b10;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    offnariscv_axi_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

    offnariscv_axi_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MEM_BYTES(65536)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed { logic [63:0] data; logic [3:0] id; logic [1:0] resp; logic last; } rexp_t;
    typedef struct packed { logic [3:0] id; logic [1:0] resp; } bexp_t;

    rexp_t rq[$];
    bexp_t bq[$];
    int    grants[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    r_count = 0;
    int    b_count = 0;
    logic [63:0] wbuf [16];
    logic        hold_v = 1'b0;
    logic [68:0] hold_val;
    logic        tog_done;
    rexp_t       re;
    bexp_t       be;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic push_r(input logic [63:0] d, input logic [3:0] id, input logic [1:0] resp, input logic last);
        rq.push_back({d, id, resp, last});
    endtask

    // Monitor: pops expectations on every R/B handshake and checks stall stability.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && bus.rvalid) check("r_stable", {bus.rdata, bus.rlast, bus.rid}, hold_val);
            hold_v   = bus.rvalid && !bus.rready;
            hold_val = {bus.rdata, bus.rlast, bus.rid};
            if (bus.rvalid && bus.rready) begin
                if (rq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL r_unexpected: got beat 0x%0h, none expected", bus.rdata);
                end else begin
                    re = rq.pop_front();
                    check("r_beat", {bus.rdata, bus.rid, bus.rresp, bus.rlast}, re);
                end
                r_count++;
            end
            if (bus.bvalid && bus.bready) begin
                if (bq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL b_unexpected: got bresp %0d, none expected", bus.bresp);
                end else begin
                    be = bq.pop_front();
                    check("b_resp", {bus.bid, bus.bresp}, be);
                end
                b_count++;
            end
            if (bus.arvalid && bus.arready) grants.push_back(0);
            if (bus.awvalid && bus.awready) grants.push_back(1);
        end
    end

    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [3:0] id);
        int target, cyc;
        target = r_count + int'(len) + 1;
        @(posedge clk); #1;
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arburst = burst; bus.arvalid = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!bus.arready && cyc < 200);
        if (!bus.arready) begin fail_now("ar_timeout"); bus.arvalid = 1'b0; return; end
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        @(negedge clk);
        check("r_latency", bus.rvalid, 1'b1);
        cyc = 0;
        while (r_count < target && cyc < 500) begin @(negedge clk); cyc++; end
        if (r_count < target) fail_now("r_timeout");
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [3:0] id, input logic [7:0] strb, input logic early_last,
                             input logic [1:0] exp_resp);
        int target, cyc;
        bq.push_back({id, exp_resp});
        target = b_count + 1;
        @(posedge clk); #1;
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awburst = burst; bus.awvalid = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!bus.awready && cyc < 200);
        if (!bus.awready) begin fail_now("aw_timeout"); bus.awvalid = 1'b0; return; end
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            bus.wdata  = wbuf[i];
            bus.wstrb  = strb;
            bus.wlast  = early_last ? (i == 0) : (i == int'(len));
            bus.wvalid = 1'b1;
            cyc = 0;
            do begin @(negedge clk); cyc++; end while (!bus.wready && cyc < 200);
            if (!bus.wready) begin fail_now("w_timeout"); bus.wvalid = 1'b0; return; end
            @(posedge clk); #1;
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        cyc = 0;
        while (b_count < target && cyc < 200) begin @(negedge clk); cyc++; end
        if (b_count < target) fail_now("b_timeout");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_g [3];
        exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awburst = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arburst = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rvalid", bus.rvalid, 1'b0);
        check("rst_bvalid", bus.bvalid, 1'b0);
        check("rst_arready", bus.arready, 1'b0);
        check("rst_awready", bus.awready, 1'b0);
        check("rst_rdata", {bus.rdata, bus.rid, bus.rresp}, 70'd0);
        check("rst_b", {bus.bid, bus.bresp}, 6'd0);
        rst = 1'b0;

        // Single write then read
        wbuf[0] = 64'h1122334455667788;
        axi_write(32'h100, 8'd0, INCR, 4'h3, 8'hFF, 1'b0, OK);
        push_r(64'h1122334455667788, 4'h5, OK, 1'b1);
        axi_read(32'h100, 8'd0, INCR, 4'h5);

        // Strobes
        wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        axi_write(32'h200, 8'd0, INCR, 4'h1, 8'hFF, 1'b0, OK);
        wbuf[0] = 64'h0;
        axi_write(32'h200, 8'd0, INCR, 4'h2, 8'h0F, 1'b0, OK);
        push_r(64'hFFFF_FFFF_0000_0000, 4'h2, OK, 1'b1);
        axi_read(32'h200, 8'd0, INCR, 4'h2);

        // Bursts
        wbuf[0] = 64'd1; wbuf[1] = 64'd2; wbuf[2] = 64'd3; wbuf[3] = 64'd4;
        axi_write(32'h0, 8'd3, INCR, 4'h4, 8'hFF, 1'b0, OK);
        push_r(64'd3, 4'h6, OK, 1'b0); push_r(64'd4, 4'h6, OK, 1'b0);
        push_r(64'd1, 4'h6, OK, 1'b0); push_r(64'd2, 4'h6, OK, 1'b1);
        axi_read(32'h10, 8'd3, WRAP, 4'h6);
        push_r(64'd2, 4'h7, OK, 1'b0); push_r(64'd2, 4'h7, OK, 1'b0); push_r(64'd2, 4'h7, OK, 1'b1);
        axi_read(32'h8, 8'd2, FIXED, 4'h7);

        // Errors
        push_r(64'd1, 4'h8, SE, 1'b0); push_r(64'd2, 4'h8, SE, 1'b0); push_r(64'd3, 4'h8, SE, 1'b1);
        axi_read(32'h0, 8'd2, WRAP, 4'h8);
        push_r(64'd1, 4'h9, SE, 1'b0); push_r(64'd2, 4'h9, SE, 1'b1);
        axi_read(32'h0, 8'd1, RSVD, 4'h9);
        wbuf[0] = 64'hA5A5_0000_0000_00A5; wbuf[1] = 64'h5A5A_0000_0000_005A;
        axi_write(32'h400, 8'd1, INCR, 4'hA, 8'hFF, 1'b1, SE);
        push_r(64'hA5A5_0000_0000_00A5, 4'hA, OK, 1'b0); push_r(64'h5A5A_0000_0000_005A, 4'hA, OK, 1'b1);
        axi_read(32'h400, 8'd1, INCR, 4'hA);

        // Backpressure with rready toggling
        push_r(64'd1, 4'hB, OK, 1'b0); push_r(64'd2, 4'hB, OK, 1'b0);
        push_r(64'd3, 4'hB, OK, 1'b0); push_r(64'd4, 4'hB, OK, 1'b1);
        tog_done = 1'b0;
        fork
            begin axi_read(32'h0, 8'd3, INCR, 4'hB); tog_done = 1'b1; end
            begin
                while (!tog_done) begin @(posedge clk); #1; bus.rready = ~bus.rready; end
                bus.rready = 1'b1;
            end
        join

        // Arbitration: a write last leaves priority with reads, so grants go R, W, R
        wbuf[0] = 64'h0;
        axi_write(32'h500, 8'd0, INCR, 4'hC, 8'hFF, 1'b0, OK);
        grants.delete();
        wbuf[0] = 64'hCAFE_F00D_1234_5678;
        push_r(64'h1122334455667788, 4'h6, OK, 1'b1);
        push_r(64'h1122334455667788, 4'h7, OK, 1'b1);
        fork
            begin axi_read(32'h100, 8'd0, INCR, 4'h6); axi_read(32'h100, 8'd0, INCR, 4'h7); end
            axi_write(32'h300, 8'd0, INCR, 4'hD, 8'hFF, 1'b0, OK);
        join
        check("grant_count", grants.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (grants.size() > i) check("grant_order", grants[i], exp_g[i]);
        end
        push_r(64'hCAFE_F00D_1234_5678, 4'hE, OK, 1'b1);
        axi_read(32'h300, 8'd0, INCR, 4'hE);

        // Reset on beat 1 of a len7 read
        push_r(64'd1, 4'h9, OK, 1'b0);
        @(posedge clk); #1;
        bus.arid = 4'h9; bus.araddr = 32'h0; bus.arlen = 8'd7; bus.arburst = INCR; bus.arvalid = 1'b1;
        @(negedge clk);
        check("rst_test_arready", bus.arready, 1'b1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        @(posedge clk); #1;
        check("rst_test_beat1_valid", bus.rvalid, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_rvalid_drop", bus.rvalid, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rq_after_rst", rq.size(), 0);
        @(posedge clk); #1;
        bus.arid = 4'h3; bus.araddr = 32'h100; bus.arlen = 8'd0; bus.arburst = INCR; bus.arvalid = 1'b1;
        push_r(64'h1122334455667788, 4'h3, OK, 1'b1);
        @(negedge clk);
        check("arready_after_rst", bus.arready, 1'b1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        repeat (3) @(negedge clk);

        // INCR wraps modulo MEM_BYTES, and upper address bits alias
        wbuf[0] = 64'hAA; wbuf[1] = 64'hBB;
        axi_write(32'hFFF8, 8'd1, INCR, 4'h1, 8'hFF, 1'b0, OK);
        push_r(64'hAA, 4'h2, OK, 1'b0); push_r(64'hBB, 4'h2, OK, 1'b1);
        axi_read(32'hFFF8, 8'd1, INCR, 4'h2);
        push_r(64'hBB, 4'h4, OK, 1'b1);
        axi_read(32'h0001_0000, 8'd0, INCR, 4'h4);

        repeat (3) @(negedge clk);
        check("rq_drained", rq.size(), 0);
        check("bq_drained", bq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
